// File: rtl/rs485_pkg.sv
// Shared RS-485 definitions: receive FSM states, packet/byte widths
// and the bit period shared by the receiver and the transmitter.
package rs485_pkg;

  localparam int RS485_PKT_W        = 16;
  localparam int RS485_BYTE_W       = 8;
  localparam int RS485_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/rs485_bit_sampler.sv
// Rx front end: 2-FF synchroniser, falling-edge detect and mid-bit tick.
// Ports: clk_i/rst_i, rx_i (raw line), restart_i (re-phase the tick),
//        rx_o (synchronised line), fall_o (falling edge), tick_o (mid-bit).
module rs485_bit_sampler #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic restart_i,
  output logic rx_o,
  output logic fall_o,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  // [1:0] synchroniser, [2] previous synchronised value
  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
      cnt_q  <= cnt_d;
    end
  end

  // Loading HALF on restart puts the first tick half a bit after
  // the start edge; later ticks follow every full bit period.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i)
      cnt_d = HALF;
    else if (cnt_q == LAST)
      cnt_d = '0;
  end

  assign rx_o   = sync_q[1];
  assign fall_o = sync_q[2] & ~sync_q[1];
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/rs485_rx_deframer.sv
// RS-485 receive deframer: 8N1 bytes paired into 16-bit packets (hi first)
// and pushed into the RX FIFO. Ports: PCLK, PRESETN (async, active-high),
// Rx, Tx_Enable, fifo_full in; fifo_wr, fifo_data, frame_err, overrun,
// timeout, busy out.
module rs485_rx_deframer
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = RS485_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic                   PCLK,
  input  logic                   PRESETN,
  input  logic                   Rx,
  input  logic                   Tx_Enable,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic [RS485_PKT_W-1:0] fifo_data,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   timeout,
  output logic                   busy
);

  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic rx_s, fall, tick;
  logic start_go, abort, stop_smp;

  rx_state_t state_q, state_d;

  logic [2:0]              bit_q, bit_d;
  logic [RS485_BYTE_W-1:0] sr_q, sr_d;
  logic [RS485_BYTE_W-1:0] hi_q, hi_d;
  logic                    half_q, half_d;
  logic [RS485_PKT_W-1:0]  data_q, data_d;
  logic                    pkt_q, pkt_d;
  logic                    ferr_q, ferr_d;
  logic                    to_q, to_d;
  logic [TW-1:0]           idle_q, idle_d;

  rs485_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk_i    (PCLK),
    .rst_i    (PRESETN),
    .rx_i     (Rx),
    .restart_i(start_go),
    .rx_o     (rx_s),
    .fall_o   (fall),
    .tick_o   (tick)
  );

  assign start_go = (state_q == IDLE) && fall && !Tx_Enable;
  // A frame can only begin with Tx_Enable low, so seeing it high
  // outside IDLE is exactly a rising edge during reception.
  assign abort    = (state_q != IDLE) && Tx_Enable;
  assign stop_smp = (state_q == STOP) && tick && !abort;

  always_ff @(posedge PCLK or posedge PRESETN) begin
    if (PRESETN)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (start_go) state_d = START;
        START: if (tick) state_d = rx_s ? IDLE : DATA;
        DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
        STOP:  if (tick) state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_d  = bit_q;
    sr_d   = sr_q;
    hi_d   = hi_q;
    half_d = half_q;
    data_d = data_q;
    pkt_d  = 1'b0;
    ferr_d = stop_smp && !rx_s;
    to_d   = 1'b0;
    idle_d = '0;

    if (start_go)
      bit_d = '0;
    else if (state_q == DATA && tick) begin
      bit_d = bit_q + 3'd1;
      sr_d  = {rx_s, sr_q[RS485_BYTE_W-1:1]};
    end

    if (stop_smp) begin
      if (!rx_s) begin
        half_d = 1'b0;
      end else if (half_q) begin
        data_d = {hi_q, sr_q};
        pkt_d  = 1'b1;
        half_d = 1'b0;
      end else begin
        hi_d   = sr_q;
        half_d = 1'b1;
      end
    end

    if (state_q == IDLE && half_q && !start_go) begin
      if (idle_q == TO_LAST) begin
        half_d = 1'b0;
        to_d   = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESETN) begin
    if (PRESETN) begin
      bit_q  <= '0;
      sr_q   <= '0;
      hi_q   <= '0;
      half_q <= 1'b0;
      data_q <= '0;
      pkt_q  <= 1'b0;
      ferr_q <= 1'b0;
      to_q   <= 1'b0;
      idle_q <= '0;
    end else begin
      bit_q  <= bit_d;
      sr_q   <= sr_d;
      hi_q   <= hi_d;
      half_q <= half_d;
      data_q <= data_d;
      pkt_q  <= pkt_d;
      ferr_q <= ferr_d;
      to_q   <= to_d;
      idle_q <= idle_d;
    end
  end

  // The push decision uses fifo_full in the cycle the packet is offered.
  always_comb begin
    fifo_wr   = pkt_q & ~fifo_full;
    overrun   = pkt_q & fifo_full;
    fifo_data = data_q;
    frame_err = ferr_q;
    timeout   = to_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_rs485_rx_deframer.sv
// Self-checking bench for rs485_rx_deframer: directed cases plus random
// byte streams checked against a packet-level model and event scoreboard.
module tb_rs485_rx_deframer;

  localparam int CPB  = 16;
  localparam int TOB  = 24;
  localparam int HALF = CPB / 2;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b1;
  logic        Rx = 1'b1;
  logic        Tx_Enable = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr;
  logic [15:0] fifo_data;
  logic        frame_err;
  logic        overrun;
  logic        timeout;
  logic        busy;

  rs485_rx_deframer #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .Rx       (Rx),
    .Tx_Enable(Tx_Enable),
    .fifo_full(fifo_full),
    .fifo_wr  (fifo_wr),
    .fifo_data(fifo_data),
    .frame_err(frame_err),
    .overrun  (overrun),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int stop_cyc = 0;
  int ferr_seen = 0, ovr_seen = 0, to_seen = 0;
  int exp_ferr = 0, exp_ovr = 0, exp_to = 0;
  bit busy_seen = 0;
  logic [15:0] exp_q[$];
  bit m_half = 0;
  logic [7:0] m_hi = 8'h00;

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Packet-level model: what a received byte means for the stream.
  task automatic model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      exp_ferr++;
      m_half = 0;
    end else if (!m_half) begin
      m_hi = b;
      m_half = 1;
    end else begin
      m_half = 0;
      if (fifo_full) exp_ovr++;
      else exp_q.push_back({m_hi, b});
    end
  endtask

  task automatic drive_bit(input logic v);
    Rx = v;
    repeat (CPB) @(negedge PCLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ok,
                           input bit modeled);
    if (modeled) model_byte(b, ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    stop_cyc = cyc;
    drive_bit(ok);
    Rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    Rx = 1'b1;
    repeat (n * CPB) @(negedge PCLK);
  endtask

  task automatic check_phase(input string name);
    repeat (2 * CPB) @(negedge PCLK);
    check({name, "_pending_wr"}, 16'(exp_q.size()), 16'd0);
    check({name, "_frame_err"}, 16'(ferr_seen), 16'(exp_ferr));
    check({name, "_overrun"}, 16'(ovr_seen), 16'(exp_ovr));
    check({name, "_timeout"}, 16'(to_seen), 16'(exp_to));
    check({name, "_busy"}, 16'(busy), 16'd0);
  endtask

  task automatic monitor();
    int d;
    logic [15:0] e;
    forever begin
      @(negedge PCLK);
      d = cyc - stop_cyc;
      if (busy) busy_seen = 1;
      if (fifo_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got %h expected none", fifo_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", fifo_data, e);
        end
        check("wr_latency_ok", 16'(d >= HALF && d < CPB), 16'd1);
        check("wr_while_full", 16'(fifo_full), 16'd0);
      end
      if (frame_err) begin
        ferr_seen++;
        check("ferr_latency_ok", 16'(d >= HALF && d < CPB), 16'd1);
      end
      if (overrun) begin
        ovr_seen++;
        check("ovr_latency_ok", 16'(d >= HALF && d < CPB), 16'd1);
      end
      if (timeout) to_seen++;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge PCLK);
    check("rst_fifo_wr", 16'(fifo_wr), 16'd0);
    check("rst_fifo_data", fifo_data, 16'h0000);
    check("rst_frame_err", 16'(frame_err), 16'd0);
    check("rst_overrun", 16'(overrun), 16'd0);
    check("rst_timeout", 16'(timeout), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    PRESETN = 1'b0;
    idle_bits(2);

    // 1: back-to-back pair
    send_byte(8'hA5, 1, 1);
    send_byte(8'h3C, 1, 1);
    check_phase("t1");
    check("t1_data", fifo_data, 16'hA53C);

    // 2: bad stop on the second byte, then a clean pair
    send_byte(8'h99, 1, 1);
    send_byte(8'h66, 0, 1);
    idle_bits(2);
    send_byte(8'h12, 1, 1);
    send_byte(8'h34, 1, 1);
    check_phase("t2");
    check("t2_data", fifo_data, 16'h1234);
    check("t2_ferr_lit", 16'(ferr_seen), 16'd1);

    // 3: FIFO full drops the packet
    fifo_full = 1'b1;
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    idle_bits(1);
    fifo_full = 1'b0;
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    check_phase("t3");
    check("t3_data", fifo_data, 16'h0102);
    check("t3_ovr_lit", 16'(ovr_seen), 16'd1);

    // 4: orphan high byte times out
    send_byte(8'h77, 1, 1);
    idle_bits(TOB - 2);
    check("t4_no_early_timeout", 16'(to_seen), 16'(exp_to));
    idle_bits(4);
    exp_to++;
    m_half = 0;
    send_byte(8'h11, 1, 1);
    send_byte(8'h22, 1, 1);
    check_phase("t4");
    check("t4_data", fifo_data, 16'h1122);
    check("t4_to_lit", 16'(to_seen), 16'd1);

    // 5: glitch, echo frame, and abort that keeps the half packet
    Rx = 1'b0;
    repeat (3) @(negedge PCLK);
    Rx = 1'b1;
    idle_bits(2);
    check_phase("t5a");
    busy_seen = 0;
    Tx_Enable = 1'b1;
    send_byte(8'h3A, 1, 0);
    idle_bits(1);
    Tx_Enable = 1'b0;
    idle_bits(1);
    check("t5_busy_seen", 16'(busy_seen), 16'd0);
    check_phase("t5b");
    send_byte(8'h5A, 1, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    Tx_Enable = 1'b1;
    for (int i = 0; i < 6; i++) drive_bit(1'b1);
    Tx_Enable = 1'b0;
    idle_bits(1);
    send_byte(8'hC3, 1, 1);
    check_phase("t5c");
    check("t5_data", fifo_data, 16'h5AC3);

    // 6: reset mid-DATA of a high byte
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #2 PRESETN = 1'b1;
    #1;
    check("t6_fifo_wr", 16'(fifo_wr), 16'd0);
    check("t6_fifo_data", fifo_data, 16'h0000);
    check("t6_frame_err", 16'(frame_err), 16'd0);
    check("t6_busy", 16'(busy), 16'd0);
    Rx = 1'b1;
    m_half = 0;
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b0;
    idle_bits(1);
    send_byte(8'hDE, 1, 1);
    send_byte(8'hAD, 1, 1);
    check_phase("t6");
    check("t6_data", fifo_data, 16'hDEAD);

    // random stream
    for (int n = 0; n < 48; n++) begin
      logic [7:0] b;
      logic ok;
      int gap;
      b = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      gap = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      send_byte(b, ok, 1);
      idle_bits(gap);
    end
    fifo_full = 1'b0;
    check_phase("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
